layer_sequencer: RTL and testbench

//   Sequences AddressGenerator across a multi-layer network: holds a per-layer neuron-count table.

---
 rtl/layer_sequencer.sv | 131 +++++++++++++
 tb/tb_layer_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps an AddressGenerator through each layer of a network and drives MAC/neuron-write control
// Ports: clk/reset (sync, active-high); cfg_we/cfg_addr/cfg_nk write the per-layer neuron-count table while idle;
//   num_layers/start launch a run, busy/done/layer_idx report it; ag_* talk to the AddressGenerator;
//   acc_clear/acc_en drive the MAC accumulator; neuron_we writes each finished neuron (one cycle late).
// Option: define LAYER_SEQ_LAYER_DONE_EN to add layer_done, pulsing with each ag_finished seen in RUN.
module layer_sequencer #(
  parameter int IP_DATA_BUS_WIDTH = 16,
  parameter int NEURON_ADDRESS_BUS_WIDTH = 8,
  parameter int WEIGHTS_ADDRESS_BUS_WIDTH = 16,
  parameter int LAYER_IDX_WIDTH = 3,
  parameter int W_BASE_INIT = 0,
  parameter int N_BASE_INIT = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_we,
  input  logic [LAYER_IDX_WIDTH-1:0]           cfg_addr,
  input  logic [IP_DATA_BUS_WIDTH-1:0]         cfg_nk,
  input  logic [LAYER_IDX_WIDTH-1:0]           num_layers,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [LAYER_IDX_WIDTH-1:0]           layer_idx,
  output logic                                 ag_read,
  output logic [IP_DATA_BUS_WIDTH-1:0]         ag_Nk,
  output logic [WEIGHTS_ADDRESS_BUS_WIDTH-1:0] ag_w_base,
  output logic [NEURON_ADDRESS_BUS_WIDTH-1:0]  ag_nr_base,
  output logic [NEURON_ADDRESS_BUS_WIDTH-1:0]  ag_nw_base,
  input  logic                                 ag_finished,
  input  logic                                 ag_neuron_fin,
  output logic                                 acc_clear,
  output logic                                 acc_en,
  output logic                                 neuron_we
`ifdef LAYER_SEQ_LAYER_DONE_EN
  ,
  output logic                                 layer_done
`endif
);
  localparam int D = IP_DATA_BUS_WIDTH;
  localparam int NA = NEURON_ADDRESS_BUS_WIDTH;
  localparam int WA = WEIGHTS_ADDRESS_BUS_WIDTH;
  localparam int L = LAYER_IDX_WIDTH;
  typedef enum logic [2:0] {IDLE, PRIME, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [D-1:0] tbl_q [2**L];
  logic [L-1:0] layer_idx_q, nl_q, sh_a_q;
  logic [WA-1:0] w_q, w_h_q;
  logic [NA-1:0] nr_q, nw_q, nr_h_q, nw_h_q;
  logic [D-1:0] nk_h_q, sh_val_q, nk0, nkl;
  logic clr_q, nwe_q, sh_v_q, last;
  // A table write coinciding with start must not affect the run it launches: the overwritten entry is shadowed.
  assign nk0 = (sh_v_q && sh_a_q == '0) ? sh_val_q : tbl_q[0];
  assign nkl = (sh_v_q && sh_a_q == layer_idx_q) ? sh_val_q : tbl_q[layer_idx_q];
  assign last = layer_idx_q == nl_q;
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start ? (num_layers == '0 ? DONE : PRIME) : IDLE;
      PRIME: state_d = LOAD;
      LOAD:  state_d = RUN;
      RUN:   state_d = ag_finished ? (last ? DONE : LOAD) : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    layer_idx = layer_idx_q;
    ag_read = state_q == PRIME || state_q == LOAD;
    ag_Nk = state_q == PRIME ? nk0 : state_q == LOAD ? nkl : nk_h_q;
    ag_w_base = state_q == LOAD ? w_q : w_h_q;
    ag_nr_base = state_q == LOAD ? nr_q : nr_h_q;
    ag_nw_base = state_q == LOAD ? nw_q : nw_h_q;
    acc_en = state_q == RUN;
    acc_clear = state_q == RUN && clr_q;
    neuron_we = nwe_q;
`ifdef LAYER_SEQ_LAYER_DONE_EN
    layer_done = state_q == RUN && ag_finished;
`endif
  end
  always_ff @(posedge clk)
    if (cfg_we && state_q == IDLE) tbl_q[cfg_addr] <= cfg_nk;
  always_ff @(posedge clk) begin
    if (reset) begin
      layer_idx_q <= '0;
      nl_q <= '0;
      w_q <= WA'(W_BASE_INIT);
      nr_q <= NA'(N_BASE_INIT);
      nw_q <= NA'(N_BASE_INIT);
      w_h_q <= '0;
      nr_h_q <= '0;
      nw_h_q <= '0;
      nk_h_q <= '0;
      clr_q <= 1'b0;
      nwe_q <= 1'b0;
      sh_v_q <= 1'b0;
      sh_a_q <= '0;
      sh_val_q <= '0;
    end else begin
      nk_h_q <= ag_Nk;
      w_h_q <= ag_w_base;
      nr_h_q <= ag_nr_base;
      nw_h_q <= ag_nw_base;
      clr_q <= state_q == LOAD || (state_q == RUN && ag_neuron_fin);
      nwe_q <= state_q == RUN && ag_neuron_fin;
      if (state_q == IDLE) begin
        sh_v_q <= start && cfg_we;
        sh_a_q <= cfg_addr;
        sh_val_q <= tbl_q[cfg_addr];
        if (start) nl_q <= num_layers;
      end
      if (state_q == PRIME) begin
        layer_idx_q <= L'(1);
        w_q <= WA'(W_BASE_INIT);
        nr_q <= NA'(N_BASE_INIT);
        nw_q <= NA'(N_BASE_INIT) + nk0[NA-1:0];
      end
      if (state_q == RUN) begin
        w_q <= w_q + WA'(1);
        if (ag_finished && !last) begin
          layer_idx_q <= layer_idx_q + L'(1);
          nr_q <= nw_q;
          nw_q <= nw_q + nkl[NA-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed self-checking bench for layer_sequencer with a behavioural AddressGenerator
module tb_layer_sequencer;
  logic clk = 1'b0, reset = 1'b1, cfg_we = 1'b0, start = 1'b0;
  logic [2:0] cfg_addr = '0, num_layers = '0, layer_idx;
  logic [15:0] cfg_nk = '0, ag_Nk, ag_w_base;
  logic [7:0] ag_nr_base, ag_nw_base;
  logic busy, done, ag_read, acc_clear, acc_en, neuron_we, ag_finished, ag_neuron_fin;
`ifdef LAYER_SEQ_LAYER_DONE_EN
  logic layer_done;
`endif
  int checks = 0, fails = 0;
  int tbl_m [8];
  int run_cnt = 0, prv, cur;
  layer_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_nk(cfg_nk),
    .num_layers(num_layers), .start(start), .busy(busy), .done(done), .layer_idx(layer_idx),
    .ag_read(ag_read), .ag_Nk(ag_Nk), .ag_w_base(ag_w_base), .ag_nr_base(ag_nr_base),
    .ag_nw_base(ag_nw_base), .ag_finished(ag_finished), .ag_neuron_fin(ag_neuron_fin),
    .acc_clear(acc_clear), .acc_en(acc_en), .neuron_we(neuron_we)
`ifdef LAYER_SEQ_LAYER_DONE_EN
    , .layer_done(layer_done)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) run_cnt <= acc_en ? run_cnt + 1 : 0;
  always_comb begin
    prv = layer_idx == 3'd0 ? 1 : tbl_m[layer_idx - 3'd1];
    cur = tbl_m[layer_idx];
    ag_neuron_fin = acc_en && (run_cnt % prv == prv - 1);
    ag_finished = acc_en && (run_cnt == prv * cur - 1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int a, input int v);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_nk = 16'(v);
    tick();
    cfg_we = 1'b0;
    tbl_m[a] = v;
  endtask
  task automatic pulse_start(input int n);
    num_layers = 3'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = done;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, ag_read, acc_en, acc_clear, neuron_we} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, ag_read, acc_en, acc_clear, neuron_we});
    end
    checks++;
    if ({layer_idx, ag_Nk, ag_w_base, ag_nr_base, ag_nw_base} !== '0) begin
      fails++;
      $display("FAIL reset_data got idx=%0d nk=%0d w=%0d nr=%0d nw=%0d exp all 0", layer_idx, ag_Nk, ag_w_base, ag_nr_base, ag_nw_base);
    end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_single_layer;
    logic [4:0] exp;
    cfg(0, 2);
    cfg(1, 3);
    pulse_start(1);
    checks++;
    if ({busy, ag_read, ag_Nk} !== {1'b1, 1'b1, 16'd2}) begin
      fails++;
      $display("FAIL prime got busy=%b read=%b nk=%0d exp 1 1 2", busy, ag_read, ag_Nk);
    end
    tick();
    checks++;
    if ({ag_read, ag_Nk, ag_w_base, ag_nr_base, ag_nw_base, layer_idx} !== {1'b1, 16'd3, 16'd0, 8'd0, 8'd2, 3'd1}) begin
      fails++;
      $display("FAIL load1 got read=%b nk=%0d w=%0d nr=%0d nw=%0d idx=%0d exp 1 3 0 0 2 1", ag_read, ag_Nk, ag_w_base, ag_nr_base, ag_nw_base, layer_idx);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = {1'b1, i % 2 == 0, 1'b0, i == 2 || i == 4, 1'b0};
      checks++;
      if ({acc_en, acc_clear, ag_read, neuron_we, done} !== exp) begin
        fails++;
        $display("FAIL run_cycle%0d en/clr/read/we/done got=%b exp=%b", i, {acc_en, acc_clear, ag_read, neuron_we, done}, exp);
      end
    end
    checks++;
    if (ag_Nk !== 16'd3) begin
      fails++;
      $display("FAIL hold_nk got=%0d exp=3", ag_Nk);
    end
    tick();
    checks++;
    if ({busy, done, neuron_we, acc_en} !== 4'b1110) begin
      fails++;
      $display("FAIL done_cycle busy/done/we/en got=%b exp=1110", {busy, done, neuron_we, acc_en});
    end
    tick();
    checks++;
    if ({busy, done, neuron_we} !== 3'b000) begin
      fails++;
      $display("FAIL after_done busy/done/we got=%b exp=000", {busy, done, neuron_we});
    end
  endtask
  task automatic test_two_layers;
    int runs = 0, wes = 0, ldones = 0;
    bit got = 1'b0, seen = 1'b0;
    logic [47:0] cap = '0;
    cfg(2, 2);
    pulse_start(2);
    for (int i = 0; i < 100 && !got; i++) begin
      if (ag_read && layer_idx == 3'd2) begin
        cap = {ag_Nk, ag_w_base, ag_nr_base, ag_nw_base};
        seen = 1'b1;
      end
      runs += int'(acc_en);
      wes += int'(neuron_we);
`ifdef LAYER_SEQ_LAYER_DONE_EN
      ldones += int'(layer_done);
`endif
      got = done;
      if (!got) tick();
    end
    checks++;
    if (!got || !seen) begin
      fails++;
      $display("FAIL two_layer_progress got done=%b load2=%b exp 1 1", got, seen);
    end
    checks++;
    if (cap !== {16'd2, 16'd6, 8'd2, 8'd5}) begin
      fails++;
      $display("FAIL load2 got nk=%0d w=%0d nr=%0d nw=%0d exp 2 6 2 5", cap[47:32], cap[31:16], cap[15:8], cap[7:0]);
    end
    checks++;
    if (runs != 12) begin
      fails++;
      $display("FAIL run_cycles got=%0d exp=12", runs);
    end
    checks++;
    if (wes != 5) begin
      fails++;
      $display("FAIL neuron_we_count got=%0d exp=5", wes);
    end
`ifdef LAYER_SEQ_LAYER_DONE_EN
    checks++;
    if (ldones != 2) begin
      fails++;
      $display("FAIL layer_done_count got=%0d exp=2", ldones);
    end
`endif
    tick();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL two_layer_idle got busy=%b exp=0", busy);
    end
  endtask
  task automatic test_zero_layers;
    pulse_start(0);
    checks++;
    if ({busy, done, ag_read} !== 3'b110) begin
      fails++;
      $display("FAIL zero_first busy/done/read got=%b exp=110", {busy, done, ag_read});
    end
    tick();
    checks++;
    if ({busy, done, ag_read} !== 3'b000) begin
      fails++;
      $display("FAIL zero_second busy/done/read got=%b exp=000", {busy, done, ag_read});
    end
  endtask
  task automatic test_reset_mid;
    bit hit = 1'b0, extra = 1'b0;
    pulse_start(2);
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      hit = acc_en && layer_idx == 3'd2;
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL reach_layer2 got=0 exp=1");
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, acc_en, acc_clear, done, neuron_we, ag_read} !== 6'b0) begin
      fails++;
      $display("FAIL mid_reset busy/en/clr/done/we/read got=%b exp=000000", {busy, acc_en, acc_clear, done, neuron_we, ag_read});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      extra |= done | busy;
    end
    checks++;
    if (extra) begin
      fails++;
      $display("FAIL post_reset_quiet got activity=1 exp=0");
    end
    test_single_layer();
  endtask
  task automatic test_busy_ignore;
    bit ok;
    pulse_start(1);
    tick();
    tick();
    cfg_we = 1'b1;
    cfg_addr = 3'd1;
    cfg_nk = 16'd9;
    start = 1'b1;
    tick();
    cfg_we = 1'b0;
    start = 1'b0;
    wait_done(ok);
    tick();
    checks++;
    if (!ok || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_ignored got done=%b busy=%b exp 1 0", ok, busy);
    end
    pulse_start(1);
    tick();
    checks++;
    if (ag_Nk !== 16'd3) begin
      fails++;
      $display("FAIL busy_cfg_ignored got nk=%0d exp=3", ag_Nk);
    end
    wait_done(ok);
    tick();
  endtask
  task automatic test_start_cfg_same;
    bit ok;
    num_layers = 3'd1;
    start = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 3'd0;
    cfg_nk = 16'd5;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    checks++;
    if (ag_Nk !== 16'd2) begin
      fails++;
      $display("FAIL same_cycle_prime got nk=%0d exp=2", ag_Nk);
    end
    tick();
    checks++;
    if (ag_nw_base !== 8'd2) begin
      fails++;
      $display("FAIL same_cycle_nw got=%0d exp=2", ag_nw_base);
    end
    wait_done(ok);
    tick();
    tbl_m[0] = 5;
    pulse_start(1);
    checks++;
    if (ag_Nk !== 16'd5) begin
      fails++;
      $display("FAIL table_written got nk=%0d exp=5", ag_Nk);
    end
    tick();
    checks++;
    if (ag_nw_base !== 8'd5) begin
      fails++;
      $display("FAIL new_nw got=%0d exp=5", ag_nw_base);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL final_run_done got=0 exp=1");
    end
    tick();
  endtask
  initial begin
    foreach (tbl_m[i]) tbl_m[i] = 1;
    test_reset();
    test_single_layer();
    test_two_layers();
    test_zero_layers();
    test_reset_mid();
    test_busy_ignore();
    test_start_cfg_same();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
